// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues icache reads and buffers words in a prefetch queue.
// Optional FETCH_BYPASS_EN: an ihit into an empty queue is presented to decode in the same cycle.
`timescale 1ns/1ps
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h00000000,
    parameter int          DEPTH   = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FULL, HALTED} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   q_pc_q   [DEPTH];
    logic [31:0]   q_pc_d   [DEPTH];
    logic [31:0]   q_word_q [DEPTH];
    logic [31:0]   q_word_d [DEPTH];

    logic hit;
    logic bypass;
    logic push;
    logic pop;
    logic flush;

    always_comb begin
        flush    = redirect && (state_q != IDLE);
        hit      = (state_q == FETCH) && ihit && !redirect;
        imemREN  = (state_q == FETCH);
        imemaddr = fetch_pc_q;
`ifdef FETCH_BYPASS_EN
        bypass      = hit && (count_q == '0);
        instr_valid = ((count_q != '0) && !redirect) || bypass;
        instr       = bypass ? imemload   : q_word_q[rd_ptr_q];
        instr_pc    = bypass ? fetch_pc_q : q_pc_q[rd_ptr_q];
`else
        bypass      = 1'b0;
        instr_valid = (count_q != '0) && !redirect;
        instr       = q_word_q[rd_ptr_q];
        instr_pc    = q_pc_q[rd_ptr_q];
`endif
        // A bypassed word taken by decode never enters the queue.
        pop  = instr_valid && instr_ready && !bypass;
        push = hit && !(bypass && instr_ready);
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        q_pc_d     = q_pc_q;
        q_word_d   = q_word_q;
        if (flush) begin
            state_d    = FETCH;
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (push) begin
                q_pc_d[wr_ptr_q]   = fetch_pc_q;
                q_word_d[wr_ptr_q] = imemload;
                wr_ptr_d           = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (hit) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            case (state_q)
                IDLE:   state_d = FETCH;
                FETCH: begin
                    if (hit && (imemload[31:26] == 6'b111111)) begin
                        state_d = HALTED;
                    end else if (count_d == FULL_CNT) begin
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (count_d < FULL_CNT) begin
                        state_d = FETCH;
                    end
                end
                HALTED: state_d = HALTED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            fetch_pc_q <= PC_INIT;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            q_pc_q     <= '{default: '0};
            q_word_q   <= '{default: '0};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            q_pc_q     <= q_pc_d;
            q_word_q   <= q_word_d;
        end
    end
endmodule
